// File: rtl/a26_cart_loader_if.sv
// a26_cart_loader_if: HPS download stream (ioctl_*) into the loader and the
// single cart RAM write/address port out of it.
interface a26_cart_loader_if #(
  parameter int ADDR_W = 15
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ram_addr, ram_din, ram_we
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/a26_cart_loader.sv
// a26_cart_loader: sequences HPS cart download, arbitrates the cart RAM port and
// holds the 2600 core in reset around loads. A26_LOAD_CKSUM_EN adds a cksum output.
module a26_cart_loader #(
  parameter int ADDR_W      = 15,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  a26_cart_loader_if.slave  bus,
  input  logic              req_reset,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_reset,
  output logic              cart_valid,
  output logic [ADDR_W-1:0] rom_mask,
  output logic [2:0]        bank_hint,
  output logic              load_done
`ifdef A26_LOAD_CKSUM_EN
  ,
  output logic [15:0]       cksum
`endif
);

  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_CNT = CNT_W'(HOLD_CYCLES);
  localparam logic [ADDR_W-1:0] MIN_MASK = ADDR_W'(2047);
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [ADDR_W-1:0] max_addr_reg, max_addr_next;
  logic [ADDR_W:0]   byte_cnt_reg, byte_cnt_next;
  logic              wr_pend_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_din_reg;
  logic              cart_valid_reg;
  logic [ADDR_W-1:0] rom_mask_reg;
  logic [2:0]        bank_hint_reg;
  logic              load_done_reg;
  logic [ADDR_W-1:0] ram_addr_mux;

  logic              in_range;
  logic              accept;
  logic              load_start;
  logic              load_end;
  logic              have_bytes;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [ADDR_W-1:0] addr_smear;
  logic [ADDR_W-1:0] commit_mask;
  logic [2:0]        commit_hint;

  assign wr_addr_in = bus.ioctl_addr[ADDR_W-1:0];
  assign in_range   = (bus.ioctl_addr >> ADDR_W) == 25'd0;
  assign accept     = bus.ioctl_wr & bus.ioctl_download & in_range;
  // Download high outside LOAD can only mean a fresh download has just begun.
  assign load_start = bus.ioctl_download & (state_reg != ST_LOAD);
  assign load_end   = (state_reg == ST_LOAD) & ~bus.ioctl_download;
  assign have_bytes = byte_cnt_reg != '0;
  assign commit     = load_end & have_bytes;

  // Propagating every set bit of max_addr downwards yields size rounded up to 2^n, minus 1.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_smear
      assign addr_smear[gi] = |max_addr_reg[ADDR_W-1:gi];
    end
  endgenerate

  assign commit_mask = addr_smear | MIN_MASK;

  always_comb begin
    commit_hint = 3'd0;
    if (32'(commit_mask) >= 32'h7FFF) begin
      commit_hint = 3'd4;
    end else if (32'(commit_mask) >= 32'h3FFF) begin
      commit_hint = 3'd3;
    end else if (32'(commit_mask) >= 32'h1FFF) begin
      commit_hint = 3'd2;
    end else if (32'(commit_mask) >= 32'h0FFF) begin
      commit_hint = 3'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    if (load_start) begin
      state_next    = ST_LOAD;
      hold_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end
        ST_LOAD: begin
          if (load_end) begin
            if (have_bytes || cart_valid_reg) begin
              state_next    = ST_HOLD;
              hold_cnt_next = HOLD_CNT;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (req_reset) begin
            hold_cnt_next = HOLD_CNT;
          end else if (hold_cnt_reg <= CNT_W'(1)) begin
            state_next    = ST_RUN;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (req_reset) begin
            state_next    = ST_HOLD;
            hold_cnt_next = HOLD_CNT;
          end
        end
        default: begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end
      endcase
    end
  end

  // Combinational terms let a new download or a reset request stop the core in the same cycle.
  always_comb begin
    core_reset   = (state_reg != ST_RUN) | bus.ioctl_download | req_reset;
    ram_addr_mux = wr_addr_reg;
    case (state_reg)
      ST_HOLD: ram_addr_mux = core_addr;
      ST_RUN:  ram_addr_mux = core_addr & rom_mask_reg;
      default: ram_addr_mux = wr_addr_reg;
    endcase
  end

  always_comb begin
    max_addr_next = load_start ? '0 : max_addr_reg;
    byte_cnt_next = load_start ? '0 : byte_cnt_reg;
    if (accept) begin
      if (wr_addr_in > max_addr_next) begin
        max_addr_next = wr_addr_in;
      end
      if (byte_cnt_next != FULL_CNT) begin
        byte_cnt_next = byte_cnt_next + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      max_addr_reg <= '0;
      byte_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      max_addr_reg <= max_addr_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_pend_reg    <= 1'b0;
      wr_addr_reg    <= '0;
      wr_din_reg     <= '0;
      cart_valid_reg <= 1'b0;
      rom_mask_reg   <= MIN_MASK;
      bank_hint_reg  <= 3'd0;
      load_done_reg  <= 1'b0;
    end else begin
      wr_pend_reg   <= accept;
      load_done_reg <= commit;
      if (accept) begin
        wr_addr_reg <= wr_addr_in;
        wr_din_reg  <= bus.ioctl_dout;
      end
      if (commit) begin
        cart_valid_reg <= 1'b1;
        rom_mask_reg   <= commit_mask;
        bank_hint_reg  <= commit_hint;
      end
    end
  end

`ifdef A26_LOAD_CKSUM_EN
  logic [15:0] sum_reg, sum_next;
  logic [15:0] cksum_reg;

  always_comb begin
    sum_next = load_start ? 16'd0 : sum_reg;
    if (accept) begin
      sum_next = sum_next + {8'd0, bus.ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_reg   <= 16'd0;
      cksum_reg <= 16'd0;
    end else begin
      sum_reg <= sum_next;
      if (commit) begin
        cksum_reg <= sum_reg;
      end
    end
  end

  assign cksum = cksum_reg;
`endif

  assign bus.ram_addr = ram_addr_mux;
  assign bus.ram_din  = wr_din_reg;
  assign bus.ram_we   = wr_pend_reg;
  assign cart_valid   = cart_valid_reg;
  assign rom_mask     = rom_mask_reg;
  assign bank_hint    = bank_hint_reg;
  assign load_done    = load_done_reg;

endmodule
